// File: rtl/pll_reset_ctrl_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// States and fixed timing constants used by pll_reset_ctrl.
package pll_reset_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RESET = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_rst_state_t;

  // Stale lock can survive the synchronizer for a few cycles after pll_rst drops.
  localparam int BLANK_CYCLES       = 4;
  localparam int LOSS_FILTER_CYCLES = 8;

endpackage

// File: rtl/pll_reset_ctrl_bit_sync.sv
// Two-flop synchronizer for a single asynchronous input.
// Both flops reset asynchronously to 0.
module bit_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer on the reference clock: pulses pll_rst, qualifies lock, releases sys_rst.
// Optional RUN-state lock-loss glitch filter: define PLL_RESET_CTRL_LOSS_FILTER_EN.
module pll_reset_ctrl
  import pll_reset_pkg::*;
#(
  parameter int RESET_PULSE_CYCLES  = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 1048576,
  parameter int RETRY_MAX           = 7
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             pll_locked,
  output logic                             pll_rst,
  output logic                             sys_rst,
  output logic                             ready,
  output logic                             fail,
  output logic [$clog2(RETRY_MAX+1)-1:0]   retry_count
);

  localparam int RC_W    = $clog2(RETRY_MAX + 1);
  localparam int MAX_AB  = (RESET_PULSE_CYCLES > LOCK_STABLE_CYCLES) ?
                           RESET_PULSE_CYCLES : LOCK_STABLE_CYCLES;
  localparam int CNT_MAX = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_N  = CNT_W'(BLANK_CYCLES);
  localparam logic [RC_W-1:0]  RC_MAX   = RC_W'(RETRY_MAX);

  function automatic logic [RC_W-1:0] retry_sat_inc(input logic [RC_W-1:0] val);
    if (val == RC_MAX) return val;
    return val + 1'b1;
  endfunction

  logic                 locked_s;
  pll_rst_state_t       state;
  pll_rst_state_t       state_nx;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nx;
  logic [RC_W-1:0]      retry_nx;

`ifdef PLL_RESET_CTRL_LOSS_FILTER_EN
  localparam int FILT_W = $clog2(LOSS_FILTER_CYCLES);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOSS_FILTER_CYCLES - 1);
  logic [FILT_W-1:0]    filt_cnt;
  logic [FILT_W-1:0]    filt_nx;
`endif

  bit_sync u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    retry_nx = retry_count;
`ifdef PLL_RESET_CTRL_LOSS_FILTER_EN
    filt_nx  = '0;
`endif
    case (state)
      ST_PLL_RESET: begin
        if (cnt == RST_LAST) begin
          state_nx = ST_WAIT_LOCK;
          cnt_nx   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock takes priority over a timeout landing on the same cycle.
        if (locked_s && (cnt >= BLANK_N)) begin
          state_nx = ST_STABLE;
          cnt_nx   = '0;
        end else if (cnt == TMO_LAST) begin
          cnt_nx   = '0;
          retry_nx = retry_sat_inc(retry_count);
          state_nx = (retry_nx == RC_MAX) ? ST_FAIL : ST_PLL_RESET;
        end
      end
      ST_STABLE: begin
        if (!locked_s) begin
          state_nx = ST_WAIT_LOCK;
          cnt_nx   = '0;
        end else if (cnt == STB_LAST) begin
          state_nx = ST_RUN;
          cnt_nx   = '0;
          retry_nx = '0;
        end
      end
      ST_RUN: begin
        cnt_nx = '0;
`ifdef PLL_RESET_CTRL_LOSS_FILTER_EN
        if (!locked_s) begin
          if (filt_cnt == FILT_LAST) state_nx = ST_PLL_RESET;
          else                       filt_nx  = filt_cnt + 1'b1;
        end
`else
        if (!locked_s) state_nx = ST_PLL_RESET;
`endif
      end
      ST_FAIL: begin
        cnt_nx = '0;
      end
      default: begin
        state_nx = ST_PLL_RESET;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs are registered straight from the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_PLL_RESET;
      cnt         <= '0;
      retry_count <= '0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      retry_count <= retry_nx;
      pll_rst     <= (state_nx == ST_PLL_RESET);
      sys_rst     <= (state_nx != ST_RUN);
      ready       <= (state_nx == ST_RUN);
      fail        <= (state_nx == ST_FAIL);
    end
  end

`ifdef PLL_RESET_CTRL_LOSS_FILTER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) filt_cnt <= '0;
    else        filt_cnt <= filt_nx;
  end
`endif

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl with small timing parameters (4/8/32/2).
// Edge numbers count rising clk edges after rst_n release.
module tb_pll_reset_ctrl;

  localparam int RPC  = 4;
  localparam int LSC  = 8;
  localparam int LTC  = 32;
  localparam int RMAX = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [1:0] retry_count;

  int errors = 0;
  int checks = 0;

  always #10 clk = ~clk;

  pll_reset_ctrl #(
    .RESET_PULSE_CYCLES  (RPC),
    .LOCK_STABLE_CYCLES  (LSC),
    .LOCK_TIMEOUT_CYCLES (LTC),
    .RETRY_MAX           (RMAX)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .pll_rst     (pll_rst),
    .sys_rst     (sys_rst),
    .ready       (ready),
    .fail        (fail),
    .retry_count (retry_count)
  );

  task automatic do_reset(input logic lock);
    @(negedge clk);
    rst_n      = 1'b0;
    pll_locked = lock;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL reset_pll_rst: got %b want 1", pll_rst); end
    checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL reset_sys_rst: got %b want 1", sys_rst); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL reset_fail: got %b want 0", fail); end
    checks++; if (retry_count !== 2'd0) begin errors++; $display("FAIL reset_retry: got %0d want 0", retry_count); end
  endtask

  task automatic test_clean_bringup();
    int n, fall_n, ready_n;
    n = 0; fall_n = 0; ready_n = 0;
    do_reset(1'b0);
    while (n < 60 && ready_n == 0) begin
      @(posedge clk); #1; n++;
      if (fall_n == 0 && pll_rst === 1'b0) fall_n = n;
      if (n == 14) pll_locked = 1'b1;
      if (ready === 1'b1) ready_n = n;
    end
    checks++; if (fall_n !== 4) begin errors++; $display("FAIL clean_pll_rst_fall: edge %0d want 4", fall_n); end
    checks++; if (ready_n !== 25) begin errors++; $display("FAIL clean_ready_edge: edge %0d want 25", ready_n); end
    checks++; if (sys_rst !== 1'b0) begin errors++; $display("FAIL clean_sys_rst: got %b want 0", sys_rst); end
    checks++; if (retry_count !== 2'd0) begin errors++; $display("FAIL clean_retry: got %0d want 0", retry_count); end
  endtask

  task automatic test_stale_lock();
    int n, ready_n;
    logic rst_again;
    n = 0; ready_n = 0; rst_again = 1'b0;
    do_reset(1'b1);
    while (n < 60 && ready_n == 0) begin
      @(posedge clk); #1; n++;
      if (n > 4 && pll_rst === 1'b1) rst_again = 1'b1;
      if (ready === 1'b1) ready_n = n;
    end
    checks++; if (ready_n !== 17) begin errors++; $display("FAIL stale_ready_edge: edge %0d want 17", ready_n); end
    checks++; if (rst_again !== 1'b0) begin errors++; $display("FAIL stale_pll_rst: extra pulse %b want 0", rst_again); end
  endtask

  task automatic test_chatter();
    int n, ready_n;
    logic rst_again;
    n = 0; ready_n = 0; rst_again = 1'b0;
    do_reset(1'b0);
    while (n < 80 && ready_n == 0) begin
      @(posedge clk); #1; n++;
      if (n == 4)  pll_locked = 1'b1;
      if (n == 12) pll_locked = 1'b0;
      if (n == 13) pll_locked = 1'b1;
      if (n > 4 && pll_rst === 1'b1) rst_again = 1'b1;
      if (ready === 1'b1) ready_n = n;
    end
    checks++; if (ready_n !== 28) begin errors++; $display("FAIL chatter_ready_edge: edge %0d want 28", ready_n); end
    checks++; if (rst_again !== 1'b0) begin errors++; $display("FAIL chatter_pll_rst: pulse seen %b want 0", rst_again); end
    checks++; if (retry_count !== 2'd0) begin errors++; $display("FAIL chatter_retry: got %0d want 0", retry_count); end
  endtask

  task automatic test_timeouts();
    int rise_n, fall_n, r1_n, fail_n, rises;
    logic prev, prst_at_fail, held;
    logic [1:0] retry_at_fail;
    rise_n = 0; fall_n = 0; r1_n = 0; fail_n = 0; rises = 0;
    prev = 1'b1; prst_at_fail = 1'bx; retry_at_fail = 2'bxx; held = 1'b1;
    do_reset(1'b0);
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk); #1;
      if (pll_rst === 1'b1 && prev === 1'b0) begin
        rises++;
        if (rise_n == 0) rise_n = n;
      end
      if (rise_n != 0 && fall_n == 0 && pll_rst === 1'b0) fall_n = n;
      if (r1_n == 0 && retry_count === 2'd1) r1_n = n;
      if (fail_n == 0 && fail === 1'b1) begin
        fail_n = n; retry_at_fail = retry_count; prst_at_fail = pll_rst;
      end
      prev = pll_rst;
    end
    checks++; if (rise_n !== 36) begin errors++; $display("FAIL tmo_pll_rst_rise: edge %0d want 36", rise_n); end
    checks++; if (fall_n - rise_n !== RPC) begin errors++; $display("FAIL tmo_pulse_len: %0d want %0d", fall_n - rise_n, RPC); end
    checks++; if (r1_n !== 36) begin errors++; $display("FAIL tmo_retry1_edge: edge %0d want 36", r1_n); end
    checks++; if (fail_n !== 72) begin errors++; $display("FAIL tmo_fail_edge: edge %0d want 72", fail_n); end
    checks++; if (retry_at_fail !== 2'd2) begin errors++; $display("FAIL tmo_retry_at_fail: got %0d want 2", retry_at_fail); end
    checks++; if (prst_at_fail !== 1'b0) begin errors++; $display("FAIL tmo_pll_rst_in_fail: got %b want 0", prst_at_fail); end
    checks++; if (rises !== 1) begin errors++; $display("FAIL tmo_pulse_count: got %0d want 1", rises); end
    repeat (1000) begin
      @(negedge clk);
      if (fail !== 1'b1 || sys_rst !== 1'b1 || retry_count !== 2'd2) held = 1'b0;
    end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL tmo_fail_sticky: held %b want 1", held); end
    @(posedge clk); #5;
    rst_n = 1'b0;
    #1;
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL tmo_rst_fail: got %b want 0", fail); end
    checks++; if (retry_count !== 2'd0) begin errors++; $display("FAIL tmo_rst_retry: got %0d want 0", retry_count); end
    checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL tmo_rst_pll_rst: got %b want 1", pll_rst); end
  endtask

  task automatic test_run_loss();
    int run_n, loss_n, prst_rise, prst_fall, rerun_n;
    int exp_loss, exp_rerun;
    logic prev_prst, rdy_at_loss;
    run_n = 0; loss_n = 0; prst_rise = 0; prst_fall = 0; rerun_n = 0;
    prev_prst = 1'b1; rdy_at_loss = 1'bx;
`ifdef PLL_RESET_CTRL_LOSS_FILTER_EN
    exp_loss = 50; exp_rerun = 67;
`else
    exp_loss = 23; exp_rerun = 40;
`endif
    do_reset(1'b0);
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk); #1;
`ifdef PLL_RESET_CTRL_LOSS_FILTER_EN
      if (n == 20 || n == 40) pll_locked = 1'b0;
      if (n == 4 || n == 27 || n == 48) pll_locked = 1'b1;
`else
      if (n == 20) pll_locked = 1'b0;
      if (n == 4 || n == 21) pll_locked = 1'b1;
`endif
      if (run_n == 0 && ready === 1'b1) run_n = n;
      if (run_n != 0 && loss_n == 0 && sys_rst === 1'b1) begin
        loss_n = n; rdy_at_loss = ready;
      end
      if (run_n != 0 && prst_rise == 0 && pll_rst === 1'b1 && prev_prst === 1'b0) prst_rise = n;
      if (prst_rise != 0 && prst_fall == 0 && pll_rst === 1'b0) prst_fall = n;
      if (loss_n != 0 && rerun_n == 0 && ready === 1'b1) rerun_n = n;
      prev_prst = pll_rst;
    end
    checks++; if (run_n !== 17) begin errors++; $display("FAIL loss_run_edge: edge %0d want 17", run_n); end
    checks++; if (loss_n !== exp_loss) begin errors++; $display("FAIL loss_sys_rst_edge: edge %0d want %0d", loss_n, exp_loss); end
    checks++; if (prst_rise !== exp_loss) begin errors++; $display("FAIL loss_pll_rst_edge: edge %0d want %0d", prst_rise, exp_loss); end
    checks++; if (prst_fall - prst_rise !== RPC) begin errors++; $display("FAIL loss_pulse_len: %0d want %0d", prst_fall - prst_rise, RPC); end
    checks++; if (rdy_at_loss !== 1'b0) begin errors++; $display("FAIL loss_ready: got %b want 0", rdy_at_loss); end
    checks++; if (rerun_n !== exp_rerun) begin errors++; $display("FAIL loss_rerun_edge: edge %0d want %0d", rerun_n, exp_rerun); end
  endtask

  task automatic test_async_reset();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL async_pre_ready: got %b want 1", ready); end
    @(posedge clk); #5;
    rst_n = 1'b0;
    #1;
    checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL async_pll_rst: got %b want 1", pll_rst); end
    checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL async_sys_rst: got %b want 1", sys_rst); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL async_ready: got %b want 0", ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_clean_bringup();
    test_stale_lock();
    test_chatter();
    test_timeouts();
    test_run_loss();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
